// File: rtl/if_pkg.sv
// Shared constants and fetch-queue entry layout for the IF stage.
package if_pkg;

  localparam int          ILEN         = 32;
  localparam int          INSTR_BYTES  = 4;
  localparam int          QDEPTH_DEF   = 2;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [ILEN-1:0] pc;
    logic            pred_taken;
    logic [ILEN-1:0] pred_pc;
    logic [ILEN-1:0] instr;
    logic            done;
    logic            kill;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch buffer: entries pushed on grant, filled by in-order responses,
// popped from the head; a redirect marks every entry killed.
module fetch_queue import if_pkg::*; #(
  parameter int QDEPTH = QDEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [ILEN-1:0] push_pc,
  input  logic            push_taken,
  input  logic [ILEN-1:0] push_pred_pc,
  input  logic            kill_all,
  input  logic            resp_valid,
  input  logic [ILEN-1:0] resp_data,
  input  logic            pop,
  output logic            full,
  output logic            head_done,
  output logic            head_kill,
  output logic [ILEN-1:0] head_pc,
  output logic            head_taken,
  output logic [ILEN-1:0] head_pred_pc,
  output logic [ILEN-1:0] head_instr
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  fetch_entry_t [QDEPTH-1:0] ent;
  fetch_entry_t              new_ent;
  logic [PW-1:0]             head_ptr, tail_ptr, resp_ptr;
  logic [CW-1:0]             count, pend;

  always_comb begin
    new_ent            = '0;
    new_ent.pc         = push_pc;
    new_ent.pred_taken = push_taken;
    new_ent.pred_pc    = push_pred_pc;
    new_ent.kill       = kill_all;
  end

  // resp_ptr tracks the oldest entry still waiting for its response
  always_ff @(posedge clk) begin
    if (rst) begin
      ent      <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      resp_ptr <= '0;
      count    <= '0;
      pend     <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (push && tail_ptr == PW'(i))
          ent[i] <= new_ent;
        if (resp_valid && resp_ptr == PW'(i)) begin
          ent[i].instr <= resp_data;
          ent[i].done  <= 1'b1;
        end
        if (kill_all)
          ent[i].kill <= 1'b1;
      end
      if (push)       tail_ptr <= tail_ptr + 1'b1;
      if (pop)        head_ptr <= head_ptr + 1'b1;
      if (resp_valid) resp_ptr <= resp_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      pend  <= pend + CW'(push) - CW'(resp_valid);
    end
  end

  assign full         = (count == CW'(QDEPTH));
  assign head_done    = (count != '0) & ent[head_ptr].done;
  assign head_kill    = ent[head_ptr].kill;
  assign head_pc      = ent[head_ptr].pc;
  assign head_taken   = ent[head_ptr].pred_taken;
  assign head_pred_pc = ent[head_ptr].pred_pc;
  assign head_instr   = ent[head_ptr].instr;

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
    resp_valid |-> pend != '0);

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage fetch unit: PC register, redirect muxing, imem issue and the
// in-order queue that feeds IF/ID.
module if_fetch_unit import if_pkg::*; #(
  parameter int               WIDTH    = ILEN,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF),
  parameter int               QDEPTH   = QDEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] pc_out,
  input  logic [WIDTH-1:0] bp_predict_pc,
  input  logic             bp_taken,
  input  logic             ex_redirect,
  input  logic [WIDTH-1:0] ex_redirect_pc,
  input  logic             csr_redirect,
  input  logic [WIDTH-1:0] csr_redirect_pc,
  input  logic             ctrl_stall,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             if_id_valid,
  output logic [WIDTH-1:0] if_id_pc,
  output logic [WIDTH-1:0] if_id_instr,
  output logic             if_id_pred_taken,
  output logic [WIDTH-1:0] if_id_pred_pc
);

  logic [WIDTH-1:0] pc, pc_nxt, redir_pc;
  logic             redir, gnt, pop;
  logic             q_full, head_done, head_kill;

  assign redir    = csr_redirect | ex_redirect;
  assign redir_pc = csr_redirect ? csr_redirect_pc : ex_redirect_pc;

  // A full queue still accepts a grant when its head leaves in the same cycle
  assign pop      = head_done & (head_kill | redir | ~ctrl_stall);
  assign imem_req = ~rst & ~(q_full & ~pop) & ~ctrl_stall;
  assign gnt      = imem_req & imem_gnt;

  always_comb begin
    pc_nxt = pc;
    if (redir)
      pc_nxt = redir_pc;
    else if (gnt)
      pc_nxt = bp_taken ? bp_predict_pc : pc + WIDTH'(INSTR_BYTES);
  end

  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_nxt;
  end

  assign pc_out    = pc;
  assign imem_addr = pc;

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push        (gnt),
    .push_pc     (pc),
    .push_taken  (bp_taken),
    .push_pred_pc(bp_predict_pc),
    .kill_all    (redir),
    .resp_valid  (imem_rvalid),
    .resp_data   (imem_rdata),
    .pop         (pop),
    .full        (q_full),
    .head_done   (head_done),
    .head_kill   (head_kill),
    .head_pc     (if_id_pc),
    .head_taken  (if_id_pred_taken),
    .head_pred_pc(if_id_pred_pc),
    .head_instr  (if_id_instr)
  );

  assign if_id_valid = head_done & ~head_kill & ~redir;

endmodule
